// File: rtl/pool_kxk.sv
// ============================================================================
//  Module   : pool_kxk
//  Purpose  : Streaming KxK max / average pooling with stride K over a
//             raster-order frame of IN_WIDTH x IN_HEIGHT signed samples.
//             A horizontal reducer folds K consecutive samples, and a line
//             buffer of IN_WIDTH/K entries folds K such partial results
//             vertically. One registered result is issued per window.
//  Options  : POOL_AVG_EN - when defined, the average mode is built and the
//             mode input is honoured. When undefined, only max pooling
//             exists and mode is ignored.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             clear      - synchronous frame restart (counters, accumulators)
//             in_valid   - in_data valid this cycle
//             in_data    - signed sample, row-major order
//             mode       - 0 = max, 1 = average (sampled per window group)
//             out_valid  - one-cycle pulse, out_data valid
//             out_data   - registered pooled result, held between pulses
//             frame_done - pulses with out_valid of the frame's last window
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pool_kxk #(
  parameter int BIT_WIDTH = 16,
  parameter int K         = 2,
  parameter int IN_WIDTH  = 28,
  parameter int IN_HEIGHT = 28
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  input  logic                        mode,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic                        frame_done
);

  localparam int LOG2K = $clog2(K);
`ifdef POOL_AVG_EN
  localparam int SH    = 2 * LOG2K;
  // Headroom for the sum of K*K samples.
  localparam int ACC_W = BIT_WIDTH + SH;
`else
  localparam int ACC_W = BIT_WIDTH;
`endif
  localparam int NCOL  = IN_WIDTH / K;
  localparam int NOROW = IN_HEIGHT / K;
  localparam int CW    = $clog2(IN_WIDTH);
  localparam int OW    = (NOROW > 1) ? $clog2(NOROW) : 1;
  localparam int IW    = (NCOL > 1) ? $clog2(NCOL) : 1;

  localparam logic [CW-1:0]    C_COL_LAST  = CW'(IN_WIDTH - 1);
  localparam logic [LOG2K-1:0] C_SUB_LAST  = LOG2K'(K - 1);
  localparam logic [OW-1:0]    C_OROW_LAST = OW'(NOROW - 1);

  // Position counters
  logic [CW-1:0]    col_q;
  logic [LOG2K-1:0] wrow_q;
  logic [OW-1:0]    orow_q;

  // Datapath state
  logic signed [ACC_W-1:0]     hacc_q;
  logic signed [ACC_W-1:0]     lbuf_q [NCOL];
  logic                        out_valid_q;
  logic                        frame_done_q;
  logic signed [BIT_WIDTH-1:0] out_data_q;

  // Next-state / combinational values
  logic signed [ACC_W-1:0]     ext_d;
  logic signed [ACC_W-1:0]     hacc_d;
  logic signed [ACC_W-1:0]     lbuf_d;
  logic signed [BIT_WIDTH-1:0] out_data_d;

  logic [IW-1:0] idx;
  logic          grp_first;
  logic          grp_last;
  logic          row_last;
  logic          col_last;
  logic          orow_last;
  logic          step;
  logic          complete;

`ifdef POOL_AVG_EN
  // Mode captured at the first sample of each K-sample group and used for
  // every combine in that group, including the line-buffer fold.
  logic mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  function automatic logic signed [ACC_W-1:0] f_max(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  assign idx       = IW'(col_q >> LOG2K);
  assign grp_first = (col_q[LOG2K-1:0] == '0);
  assign grp_last  = (col_q[LOG2K-1:0] == C_SUB_LAST);
  assign row_last  = (wrow_q == C_SUB_LAST);
  assign col_last  = (col_q == C_COL_LAST);
  assign orow_last = (orow_q == C_OROW_LAST);
  // clear discards a coincident sample
  assign step      = in_valid & ~clear;
  assign complete  = step & grp_last & row_last;

  always_comb begin
    ext_d  = ACC_W'(in_data);
    hacc_d = ext_d;
    if (!grp_first) begin
`ifdef POOL_AVG_EN
      hacc_d = mode_q ? (hacc_q + ext_d) : f_max(hacc_q, ext_d);
`else
      hacc_d = f_max(hacc_q, ext_d);
`endif
    end

    // Window row 0 loads the line-buffer entry, so its old contents never matter.
    lbuf_d = hacc_d;
    if (wrow_q != '0) begin
`ifdef POOL_AVG_EN
      lbuf_d = mode_q ? (lbuf_q[idx] + hacc_d) : f_max(lbuf_q[idx], hacc_d);
`else
      lbuf_d = f_max(lbuf_q[idx], hacc_d);
`endif
    end

`ifdef POOL_AVG_EN
    // Arithmetic shift floors toward negative infinity.
    out_data_d = mode_q ? BIT_WIDTH'(lbuf_d >>> SH) : BIT_WIDTH'(lbuf_d);
`else
    out_data_d = BIT_WIDTH'(lbuf_d);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      wrow_q       <= '0;
      orow_q       <= '0;
      hacc_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_data_q   <= '0;
`ifdef POOL_AVG_EN
      mode_q       <= 1'b0;
`endif
    end else begin
      out_valid_q  <= complete;
      frame_done_q <= complete & col_last & orow_last;
      if (complete) begin
        out_data_q <= out_data_d;
      end

      if (clear) begin
        col_q  <= '0;
        wrow_q <= '0;
        orow_q <= '0;
        hacc_q <= '0;
      end else if (in_valid) begin
        hacc_q <= hacc_d;
`ifdef POOL_AVG_EN
        if (grp_first) begin
          mode_q <= mode;
        end
`endif
        if (col_last) begin
          col_q <= '0;
          if (row_last) begin
            wrow_q <= '0;
            orow_q <= orow_last ? '0 : (orow_q + 1'b1);
          end else begin
            wrow_q <= wrow_q + 1'b1;
          end
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // Line buffer carries no reset; each entry is loaded on window row 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NCOL; i++) begin
        lbuf_q[i] <= '0;
      end
    end else if (in_valid && grp_last) begin
      lbuf_q[idx] <= lbuf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_data   = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_pool_kxk.sv
// ============================================================================
//  Module   : tb_pool_kxk
//  Purpose  : Scoreboard bench for pool_kxk. Two instances (K=2 4x2 frame and
//             K=4 8x8 frame) are driven with directed and random frames; a
//             frame-array reference model pushes expected results and a
//             monitor pops and compares on every out_valid.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pool_kxk;

  localparam int BW = 16;
  localparam int K0 = 2, W0 = 4, H0 = 2;
  localparam int K1 = 4, W1 = 8, H1 = 8;

  typedef struct {
    int data;
    int fd;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, clr0, clr1, iv0, iv1, md0, md1;
  logic signed [BW-1:0] id0, id1, od0, od1;
  logic ov0, ov1, fd0, fd1;

  pool_kxk #(.BIT_WIDTH(BW), .K(K0), .IN_WIDTH(W0), .IN_HEIGHT(H0)) u_dut0 (
    .clk(clk), .rst(rst0), .clear(clr0), .in_valid(iv0), .in_data(id0),
    .mode(md0), .out_valid(ov0), .out_data(od0), .frame_done(fd0)
  );

  pool_kxk #(.BIT_WIDTH(BW), .K(K1), .IN_WIDTH(W1), .IN_HEIGHT(H1)) u_dut1 (
    .clk(clk), .rst(rst1), .clear(clr1), .in_valid(iv1), .in_data(id1),
    .mode(md1), .out_valid(ov1), .out_data(od1), .frame_done(fd1)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   fr [2][8][8];
  int   mr [2];
  int   mc [2];
  int   last [2];
  bit   mdm [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input int id, input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL dut%0d %s: got %0d, expected %0d", id, name, got, exp);
  endtask

  // Reference model: stores the frame as a 2-D array and reduces each KxK
  // window directly once its bottom-right sample has arrived.
  task automatic push_model(input int id, input int d, input int c);
    int k, w, h, r, cl, acc, v, sh;
    bit avg;
    exp_t e;
    k  = (id == 0) ? K0 : K1;
    w  = (id == 0) ? W0 : W1;
    h  = (id == 0) ? H0 : H1;
    r  = mr[id];
    cl = mc[id];
    fr[id][r][cl] = d;
`ifdef POOL_AVG_EN
    avg = mdm[id];
`else
    avg = 1'b0;
`endif
    if ((cl % k == k - 1) && (r % k == k - 1)) begin
      acc = avg ? 0 : fr[id][r][cl];
      for (int rr = r - k + 1; rr <= r; rr++) begin
        for (int cc = cl - k + 1; cc <= cl; cc++) begin
          v = fr[id][rr][cc];
          if (avg) acc += v;
          else if (v > acc) acc = v;
        end
      end
      if (avg) begin
        sh = 0;
        for (int t = k; t > 1; t = t / 2) sh += 2;
        acc = acc >>> sh;
      end
      e.data = acc;
      e.fd   = (r == h - 1 && cl == w - 1) ? 1 : 0;
      e.cyc  = c;
      if (id == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    cl++;
    if (cl == w) begin
      cl = 0;
      r++;
      if (r == h) r = 0;
    end
    mr[id] = r;
    mc[id] = cl;
  endtask

  task automatic mon(input int id, input logic ov, input logic fd, input int od);
    exp_t e;
    int   sz;
    if (ov) begin
      sz = (id == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        n_chk++;
        $display("FAIL dut%0d unexpected out_valid: got out_data %0d, expected no pulse", id, od);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk(id, "out_data", od, e.data);
        chk(id, "frame_done", int'(fd), e.fd);
        chk(id, "pulse cycle", cyc, e.cyc);
        last[id] = e.data;
      end
    end else begin
      chk(id, "frame_done idle", int'(fd), 0);
      chk(id, "out_data hold", od, last[id]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon(0, ov0, fd0, int'(od0));
    mon(1, ov1, fd1, int'(od1));
  end

  task automatic send(input int id, input int d);
    logic m;
    @(negedge clk);
`ifdef POOL_AVG_EN
    m = mdm[id];
`else
    m = 1'($urandom);
`endif
    if (id == 0) begin
      iv0 = 1'b1; id0 = BW'(d); md0 = m;
    end else begin
      iv1 = 1'b1; id1 = BW'(d); md1 = m;
    end
    push_model(id, d, cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iv0 = 1'b0;
      iv1 = 1'b0;
    end
  endtask

  task automatic send_dir(input int n, input int gap);
    int v[8];
    v = '{1, -5, 3, 7, 2, 9, -8, 4};
    for (int i = 0; i < n; i++) begin
      send(0, v[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic rand_frame(input int id, input int maxgap);
    int n, d;
    logic signed [BW-1:0] s;
    n = (id == 0) ? W0 * H0 : W1 * H1;
    mdm[id] = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      s = BW'($urandom);
      d = s;
      send(id, d);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, maxgap));
    end
  endtask

  task automatic const_frame(input int id, input int val, input bit m);
    mdm[id] = m;
    for (int i = 0; i < W1 * H1; i++) send(id, val);
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; md0 = 1'b0; md1 = 1'b0; id0 = '0; id1 = '0;
    for (int i = 0; i < 2; i++) begin
      mr[i] = 0; mc[i] = 0; last[i] = 0; mdm[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk(0, "reset out_valid", int'(ov0), 0);
    chk(0, "reset frame_done", int'(fd0), 0);
    chk(0, "reset out_data", int'(od0), 0);
    chk(1, "reset out_valid", int'(ov1), 0);
    chk(1, "reset out_data", int'(od1), 0);
    rst0 = 1'b0; rst1 = 1'b0;
    idle(2);

    // Directed frames on the 4x2, K=2 instance
    mdm[0] = 1'b0; send_dir(8, 0); idle(2);
    mdm[0] = 1'b1; send_dir(8, 0); idle(2);
    mdm[0] = 1'b0; send_dir(8, 3); idle(2);
    mdm[0] = 1'b1; send_dir(8, 3); idle(2);

    // Reset mid-window, then replay
    mdm[0] = 1'b0; send_dir(5, 0);
    @(negedge clk);
    iv0 = 1'b0; rst0 = 1'b1;
    mr[0] = 0; mc[0] = 0; last[0] = 0; q0.delete();
    #1;
    chk(0, "mid-frame reset out_data", int'(od0), 0);
    chk(0, "mid-frame reset out_valid", int'(ov0), 0);
    @(negedge clk);
    rst0 = 1'b0;
    send_dir(8, 0); idle(2);

    // Back-to-back frames
    send_dir(8, 0); send_dir(8, 0); idle(2);

    // clear together with in_valid right after a completing sample
    send_dir(6, 0);
    @(negedge clk);
    clr0 = 1'b1; iv0 = 1'b1; id0 = 16'sd1234;
    mr[0] = 0; mc[0] = 0;
    @(negedge clk);
    clr0 = 1'b0; iv0 = 1'b0;
    send_dir(8, 0); idle(2);

    // Random frames on the K=2 instance
    for (int f = 0; f < 30; f++) rand_frame(0, 4);
    idle(3);

    // Extremes and random frames on the K=4 instance
    const_frame(1, -32768, 1'b1);
    const_frame(1, 32767, 1'b1);
    const_frame(1, -32768, 1'b0);
    for (int f = 0; f < 8; f++) rand_frame(1, 3);
    idle(6);

    chk(0, "pending expectations", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
